// File: rtl/record_play_controller.sv
// -----------------------------------------------------------------------------
// record_play_controller
//   Sequences the record/playback datapath: address counter, deserializer,
//   serializer and sample memory. The sample memory is split into NUM_SLOTS
//   equal slots. On request the block loads the address counter with the base
//   address of the selected slot. During record it gates memory writes, and it
//   tracks the recorded length of every slot. A take ends on stop, when the slot
//   is full, or when playback reaches the stored length.
//
// Ports
//   i_clock            system clock, rising edge
//   i_reset            asynchronous reset, active low
//   i_recordReq        1-cycle pulse, start recording i_slotSel
//   i_playReq          1-cycle pulse, start playing i_slotSel
//   i_stopReq          1-cycle pulse, end the current take
//   i_slotSel          slot for record/play, sampled in IDLE
//   i_desDone          deserializer has a sample (record strobe)
//   i_sDone            serializer consumed a sample (play strobe)
//   o_startCountRecord counter load, record
//   o_startCountPlay   counter load, play
//   o_startAddress     counter load value = slot base address
//   o_memWrite         memory write enable
//   o_recording        state == RECORD
//   o_playing          state == PLAY
//   o_busy             state != IDLE
//   o_done             1-cycle pulse at the end of any take
//   o_reject           1-cycle pulse when a play of an empty slot is refused
// -----------------------------------------------------------------------------
module record_play_controller #(
  parameter int ADDR_W    = 17,
  parameter int NUM_SLOTS = 4,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_recordReq,
  input  logic              i_playReq,
  input  logic              i_stopReq,
  input  logic [SLOT_W-1:0] i_slotSel,
  input  logic              i_desDone,
  input  logic              i_sDone,
  output logic              o_startCountRecord,
  output logic              o_startCountPlay,
  output logic [ADDR_W-1:0] o_startAddress,
  output logic              o_memWrite,
  output logic              o_recording,
  output logic              o_playing,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_reject
);

  localparam int SLOT_DEPTH = (2 ** ADDR_W) / NUM_SLOTS;
  // One extra bit so a completely full slot (SLOT_DEPTH samples) is representable.
  localparam int LEN_W      = $clog2(SLOT_DEPTH) + 1;
  localparam int OFF_W      = ADDR_W - SLOT_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REC  = 3'd1,
    S_RECORD    = 3'd2,
    S_LOAD_PLAY = 3'd3,
    S_PLAY      = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SLOT_W-1:0]  r_slot;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_stop_pend;
  logic               r_reject;

  logic               w_slot_load;
  logic               w_cnt_clr;
  logic               w_len_wr;
  logic               w_reject_next;
  logic               w_pend_next;
  logic               w_strobe;
  logic               w_stop_any;
  logic [LEN_W-1:0]   w_cnt_next;
  logic [LEN_W-1:0]   w_len [NUM_SLOTS];

  // A stop that arrived during a LOAD cycle is honoured at the first
  // RECORD/PLAY cycle, together with any strobe in that cycle.
  assign w_stop_any = i_stopReq | r_stop_pend;
  assign w_strobe   = ((r_state == S_RECORD) & i_desDone) |
                      ((r_state == S_PLAY)   & i_sDone);
  assign w_cnt_next = w_strobe ? (r_cnt + LEN_W'(1)) : r_cnt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_slot_load   = 1'b0;
    w_cnt_clr     = 1'b0;
    w_len_wr      = 1'b0;
    w_reject_next = 1'b0;
    w_pend_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Record has priority over play; stop is meaningless here.
        if (i_recordReq) begin
          w_state_next = S_LOAD_REC;
          w_slot_load  = 1'b1;
        end else if (i_playReq) begin
          if (w_len[i_slotSel] != '0) begin
            w_state_next = S_LOAD_PLAY;
            w_slot_load  = 1'b1;
          end else begin
            w_reject_next = 1'b1;
          end
        end
      end
      S_LOAD_REC: begin
        w_cnt_clr    = 1'b1;
        w_pend_next  = i_stopReq;
        w_state_next = S_RECORD;
      end
      S_LOAD_PLAY: begin
        w_cnt_clr    = 1'b1;
        w_pend_next  = i_stopReq;
        w_state_next = S_PLAY;
      end
      S_RECORD: begin
        if (w_stop_any || (w_strobe && (w_cnt_next == LEN_W'(SLOT_DEPTH)))) begin
          w_state_next = S_FINISH;
          w_len_wr     = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_stop_any || (w_strobe && (w_cnt_next == w_len[r_slot]))) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot, sample counter, pending stop and reject pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_slot      <= '0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_reject    <= w_reject_next;
      r_stop_pend <= w_pend_next;
      if (w_slot_load) begin
        r_slot <= i_slotSel;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slot recorded length; written only when a record take ends, so a
  // reset in the middle of a take leaves nothing behind.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [LEN_W-1:0] r_len;

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        r_len <= '0;
      end else if (w_len_wr && (r_slot == SLOT_W'(gi))) begin
        r_len <= w_cnt_next;
      end
    end

    assign w_len[gi] = r_len;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Slot base = slot index in the top address bits.
  assign o_startAddress     = {r_slot, {OFF_W{1'b0}}};
  assign o_startCountRecord = (r_state == S_LOAD_REC);
  assign o_startCountPlay   = (r_state == S_LOAD_PLAY);
  assign o_memWrite         = (r_state == S_RECORD) & i_desDone;
  assign o_recording        = (r_state == S_RECORD);
  assign o_playing          = (r_state == S_PLAY);
  assign o_busy             = (r_state != S_IDLE);
  assign o_done             = (r_state == S_FINISH);
  assign o_reject           = r_reject;

endmodule
